miriscv_lsu: RTL and testbench

MIRISCV_LSU -- requirements
Module: miriscv_lsu

---
 rtl/miriscv_lsu.sv | 179 +++++++++++++++++
 tb/tb_miriscv_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns one core memory request into one bus transaction,
// formats load data by size/sign, and flags misaligned, illegal-size and
// timed-out accesses with a single-cycle error pulse.
//
// Bus handshake: data_req_o is asserted from the cycle after a legal request
// is accepted and held, together with addr/we/be/wdata, until data_ack_i is
// seen high on a rising edge while in BUSY (or the timeout expires). An ack
// completes the transfer on that edge; acks seen outside BUSY are ignored.
module miriscv_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1 (last BUSY cycle index).
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_lsu_data;
  logic              r_err;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;

  logic              w_bad;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_timeout;
  logic [31:0]       w_shift;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;

  // Decode request size: byte enables, replicated store data, legality.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = lsu_data_i;
    w_bad   = 1'b0;
    case (lsu_size_i)
      3'b000, 3'b100: begin
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_data_i[7:0]}};
      end
      3'b001, 3'b101: begin
        w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu_data_i[15:0]}};
        w_bad   = lsu_addr_i[0];
      end
      3'b010: begin
        w_be    = 4'b1111;
        w_bad   = (lsu_addr_i[1:0] != 2'b00);
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Select and extend the load lane using the registered size/offset.
  always_comb begin
    w_shift     = data_rdata_i >> {r_addr_lo, 3'b000};
    w_half      = r_addr_lo[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    w_load_data = data_rdata_i;
    case (r_size)
      3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load_data = {24'd0, w_shift[7:0]};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = data_rdata_i;
    endcase
  end

  // Timeout fires only when the last BUSY cycle passes without an ack.
  assign w_timeout = (r_cnt == CNT_LAST) && !data_ack_i;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (lsu_req_i) w_next_state = w_bad ? DONE : BUSY;
      BUSY:    if (data_ack_i || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Bus request registers, timeout counter, load result and error pulse.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_cnt      <= '0;
      r_size     <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_lsu_data <= 32'd0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (lsu_req_i) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_req     <= 1'b1;
              r_we      <= lsu_we_i;
              r_be      <= w_be;
              r_addr    <= {lsu_addr_i[31:2], 2'b00};
              r_wdata   <= w_wdata;
              r_size    <= lsu_size_i;
              r_addr_lo <= lsu_addr_i[1:0];
              r_cnt     <= '0;
            end
          end
        end
        BUSY: begin
          if (data_ack_i) begin
            r_req <= 1'b0;
            if (!r_we) r_lsu_data <= w_load_data;
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_err      <= 1'b1;
            r_lsu_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_stall_req_o = ((r_state == IDLE) && lsu_req_i) || (r_state == BUSY);
  assign lsu_data_o      = r_lsu_data;
  assign lsu_err_o       = r_err;
  assign data_req_o      = r_req;
  assign data_we_o       = r_we;
  assign data_be_o       = r_be;
  assign data_addr_o     = r_addr;
  assign data_wdata_o    = r_wdata;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: load/store formatting, error cases,
// timeout, ack at the timeout boundary, stray acks and reset during BUSY.
module tb_miriscv_lsu;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'b000;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_data_i = 32'd0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = 32'd0;
  logic        data_ack_i = 1'b0;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  miriscv_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .reset(reset),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i), .dbg_state_o(dbg_state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access from IDLE back to IDLE. ack_at = BUSY cycle carrying the
  // ack (0 = never). Called and returns at a falling edge with the DUT idle.
  task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack_at,
                            input logic exp_err, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int exp_busy,
                            input logic [31:0] exp_ld);
    int busy_cnt;
    int stall_cnt;
    logic req_ok;
    logic [31:0] exp_v;
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wdata;
    exp_q.push_back(exp_ld);
    #1;
    chk({tag, ".stall_idle"}, 32'(lsu_stall_req_o), 32'd1);
    stall_cnt = 1;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    if (exp_busy > 0) begin
      chk({tag, ".addr"}, data_addr_o, {addr[31:2], 2'b00});
      chk({tag, ".be"}, 32'(data_be_o), 32'(exp_be));
      chk({tag, ".we"}, 32'(data_we_o), 32'(we));
      if (we) chk({tag, ".wdata"}, data_wdata_o, exp_wdata);
    end
    busy_cnt = 0;
    req_ok = 1'b1;
    while (dbg_state_o == S_BUSY && busy_cnt < 400) begin
      busy_cnt++;
      if (lsu_stall_req_o) stall_cnt++;
      if (!data_req_o) req_ok = 1'b0;
      data_ack_i   = (busy_cnt == ack_at);
      data_rdata_i = (busy_cnt == ack_at) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk_i);
    end
    data_ack_i = 1'b0;
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, ".req_held"}, 32'(req_ok), 32'd1);
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_busy + 1));
    chk({tag, ".state_done"}, 32'(dbg_state_o), 32'(S_DONE));
    chk({tag, ".req_dropped"}, 32'(data_req_o), 32'd0);
    chk({tag, ".stall_done"}, 32'(lsu_stall_req_o), 32'd0);
    chk({tag, ".err"}, 32'(lsu_err_o), 32'(exp_err));
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      chk({tag, ".ld_data"}, lsu_data_o, exp_v);
    end
    // A request raised during DONE must not start a new access.
    lsu_req_i = 1'b1;
    @(negedge clk_i);
    chk({tag, ".back_idle"}, 32'(dbg_state_o), 32'(S_IDLE));
    chk({tag, ".err_cleared"}, 32'(lsu_err_o), 32'd0);
    chk({tag, ".no_req_from_done"}, 32'(data_req_o), 32'd0);
    lsu_req_i = 1'b0;
  endtask

  initial begin
    // Reset block.
    reset = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst.state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("rst.req", 32'(data_req_o), 32'd0);
    chk("rst.we", 32'(data_we_o), 32'd0);
    chk("rst.be", 32'(data_be_o), 32'd0);
    chk("rst.addr", data_addr_o, 32'd0);
    chk("rst.wdata", data_wdata_o, 32'd0);
    chk("rst.ld", lsu_data_o, 32'd0);
    chk("rst.err", 32'(lsu_err_o), 32'd0);
    chk("rst.stall", 32'(lsu_stall_req_o), 32'd0);
    reset = 1'b0;
    @(negedge clk_i);

    //          tag     we    size    addr          wdata         rdata        ack err  be       exp_wdata     busy ld
    run_access("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 1'b0, 4'b1000, 32'h0,        1,  32'hFFFF_FF80);
    run_access("lhu",  1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_0000, 2, 1'b0, 4'b1100, 32'h0,        2,  32'h0000_8001);
    run_access("lh",   1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 1, 1'b0, 4'b1100, 32'h0,        1,  32'hFFFF_8001);
    run_access("sb",   1'b1, 3'b000, 32'h0000_0001, 32'hAABB_CCDD, 32'h1111_1111, 3, 1'b0, 4'b0010, 32'hDDDD_DDDD, 3,  32'hFFFF_8001);
    run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0,      32'h0,         1, 1'b1, 4'b0000, 32'h0,        0,  32'hFFFF_8001);
    run_access("lbu",  1'b0, 3'b100, 32'h0000_0002, 32'h0,        32'h1234_5678, 1, 1'b0, 4'b0100, 32'h0,        1,  32'h0000_0034);
    run_access("sh",   1'b1, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        1, 1'b0, 4'b1100, 32'hABCD_ABCD, 1,  32'h0000_0034);
    run_access("sw",   1'b1, 3'b010, 32'h0000_0008, 32'h0102_0304, 32'h0,        2, 1'b0, 4'b1111, 32'h0102_0304, 2,  32'h0000_0034);
    run_access("ill",  1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         1, 1'b1, 4'b0000, 32'h0,        0,  32'h0000_0034);
    run_access("lw",   1'b0, 3'b010, 32'h0000_000C, 32'h0,        32'hCAFE_F00D, 1, 1'b0, 4'b1111, 32'h0,        1,  32'hCAFE_F00D);
    run_access("lh_mis", 1'b0, 3'b001, 32'h0000_0005, 32'h0,      32'h0,         1, 1'b1, 4'b0000, 32'h0,        0,  32'hCAFE_F00D);
    run_access("lw_to", 1'b0, 3'b010, 32'h0000_0040, 32'h0,       32'h0,         0, 1'b1, 4'b1111, 32'h0,        255, 32'h0000_0000);
    run_access("lw_ack_last", 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 255, 1'b0, 4'b1111, 32'h0,     255, 32'h0BAD_F00D);

    // Stray ack while idle is ignored.
    data_ack_i   = 1'b1;
    data_rdata_i = 32'h5555_5555;
    exp_q.push_back(32'h0BAD_F00D);
    @(negedge clk_i);
    data_ack_i = 1'b0;
    chk("stray_ack.state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("stray_ack.req", 32'(data_req_o), 32'd0);
    chk("stray_ack.ld", lsu_data_o, exp_q.pop_front());

    // Reset during the third BUSY cycle.
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'b010;
    lsu_addr_i = 32'h0000_0010;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy.pre_state", 32'(dbg_state_o), 32'(S_BUSY));
    reset = 1'b1;
    @(negedge clk_i);
    chk("rst_busy.state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("rst_busy.req", 32'(data_req_o), 32'd0);
    chk("rst_busy.stall_lo", 32'(lsu_stall_req_o), 32'd0);
    chk("rst_busy.ld", lsu_data_o, 32'd0);
    chk("rst_busy.be", 32'(data_be_o), 32'd0);
    lsu_req_i = 1'b1;
    #1;
    chk("rst_busy.stall_hi", 32'(lsu_stall_req_o), 32'd1);
    @(negedge clk_i);
    chk("rst_prio.state", 32'(dbg_state_o), 32'(S_IDLE));
    chk("rst_prio.req", 32'(data_req_o), 32'd0);
    lsu_req_i = 1'b0;
    reset = 1'b0;
    @(negedge clk_i);

    // Recovery after reset.
    run_access("lbu_post", 1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'hAB00_0000, 1, 1'b0, 4'b1000, 32'h0, 1, 32'h0000_00AB);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
